// File: rtl/approx_err_pkg.sv
// rtl/approx_err_pkg.sv - shared widths, FSM state codes and saturation masks for the ED accumulator
package approx_err_pkg;

   localparam int OP_W_DEF  = 8;
   localparam int CNT_W_DEF = 16;
   localparam int SUM_W_DEF = 32;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [SUM_W_DEF-1:0]   SUM_SAT_DEF    = '1;
   localparam logic [2*SUM_W_DEF-1:0] SUM_SQ_SAT_DEF = '1;

endpackage

// File: rtl/approx_err_accum_if.sv
// rtl/approx_err_accum_if.sv - sample stream (a, b, approximate y) with valid/ready handshake
interface approx_err_accum_if #(
   parameter int OP_W = 8
);
   logic                in_valid;
   logic                in_ready;
   logic [OP_W-1:0]     in_a;
   logic [OP_W-1:0]     in_b;
   logic [2*OP_W-1:0]   in_y;

   modport master (output in_valid, output in_a, output in_b, output in_y, input in_ready);
   modport slave  (input in_valid, input in_a, input in_b, input in_y, output in_ready);
endinterface

// File: rtl/approx_ed_unit.sv
// rtl/approx_ed_unit.sv - combinational exact product and error distance |a*b - y|
module approx_ed_unit #(
   parameter int OP_W = 8
) (
   input  logic [OP_W-1:0]   a_i,
   input  logic [OP_W-1:0]   b_i,
   input  logic [2*OP_W-1:0] y_i,
   output logic [2*OP_W-1:0] ed_o
);
   logic [2*OP_W-1:0] prod;

   assign prod = {{OP_W{1'b0}}, a_i} * {{OP_W{1'b0}}, b_i};
   assign ed_o = (prod >= y_i) ? (prod - y_i) : (y_i - prod);
endmodule

// File: rtl/approx_err_accum.sv
// rtl/approx_err_accum.sv - error-distance statistics over N samples; APPROX_ERR_SQ_EN adds sum of ED^2
module approx_err_accum
   import approx_err_pkg::*;
#(
   parameter int OP_W  = OP_W_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int SUM_W = SUM_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [CNT_W-1:0]     n_samples_i,
   approx_err_accum_if.slave    s_if,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [CNT_W-1:0]     sample_count_o,
   output logic [CNT_W-1:0]     err_count_o,
   output logic [SUM_W-1:0]     sum_ed_o,
   output logic [2*OP_W-1:0]    max_ed_o
`ifdef APPROX_ERR_SQ_EN
  ,output logic [2*SUM_W-1:0]   sum_sq_ed_o
`endif
);
   localparam int P_W = 2*OP_W;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] n_q, n_d;
   logic [CNT_W-1:0] accepted_q, accepted_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, done_q;
   logic             clear;
   logic             accept;
   logic             pipe_empty;

   logic [P_W-1:0]   ed;
   logic             s1_vld_q;
   logic [P_W-1:0]   s1_ed_q;
   logic             acc_vld;
   logic [P_W-1:0]   acc_ed;

   logic [CNT_W-1:0] cnt_q, err_q;
   logic [SUM_W-1:0] sum_q, sum_d;
   logic [SUM_W:0]   sum_ext;
   logic [P_W-1:0]   max_q;

   approx_ed_unit #(.OP_W(OP_W)) u_ed (
      .a_i  (s_if.in_a),
      .b_i  (s_if.in_b),
      .y_i  (s_if.in_y),
      .ed_o (ed)
   );

   assign accept        = s_if.in_valid & in_ready_q;
   assign s_if.in_ready = in_ready_q;

`ifdef APPROX_ERR_SQ_EN
   // Extra stage squares ED so the multiplier is not in series with the accumulator adders.
   logic                 s2_vld_q;
   logic [P_W-1:0]       s2_ed_q;
   logic [2*P_W-1:0]     s2_sq_q;
   logic [2*SUM_W-1:0]   sq_sum_q, sq_sum_d;
   logic [2*SUM_W:0]     sq_ext;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld_q <= 1'b0;
         s2_ed_q  <= '0;
         s2_sq_q  <= '0;
      end else begin
         s2_vld_q <= s1_vld_q;
         s2_ed_q  <= s1_ed_q;
         s2_sq_q  <= {{P_W{1'b0}}, s1_ed_q} * {{P_W{1'b0}}, s1_ed_q};
      end
   end

   assign acc_vld    = s2_vld_q;
   assign acc_ed     = s2_ed_q;
   assign pipe_empty = !s1_vld_q && !s2_vld_q;
   assign sq_ext     = {1'b0, sq_sum_q} + {{(2*SUM_W+1-2*P_W){1'b0}}, s2_sq_q};
   assign sq_sum_d   = sq_ext[2*SUM_W] ? '1 : sq_ext[2*SUM_W-1:0];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         sq_sum_q <= '0;
      end else if (acc_vld) begin
         sq_sum_q <= sq_sum_d;
      end
   end

   assign sum_sq_ed_o = sq_sum_q;
`else
   assign acc_vld    = s1_vld_q;
   assign acc_ed     = s1_ed_q;
   assign pipe_empty = !s1_vld_q;
`endif

   always_comb begin
      state_d    = state_q;
      n_d        = n_q;
      accepted_d = accepted_q;
      in_ready_d = 1'b0;
      clear      = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_i) begin
               clear      = 1'b1;
               accepted_d = '0;
               n_d        = n_samples_i;
               if (n_samples_i == '0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d    = ST_RUN;
                  in_ready_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               accepted_d = accepted_q + CNT_W'(1);
            end
            in_ready_d = (accepted_d < n_q);
            if (!in_ready_d) begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            // No new samples enter in DRAIN, so an empty pipeline means the last update has landed.
            if (pipe_empty) begin
               state_d = ST_DONE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         n_q        <= '0;
         accepted_q <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         s1_vld_q   <= 1'b0;
         s1_ed_q    <= '0;
      end else begin
         state_q    <= state_d;
         n_q        <= n_d;
         accepted_q <= accepted_d;
         in_ready_q <= in_ready_d;
         busy_q     <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
         done_q     <= (state_d == ST_DONE);
         s1_vld_q   <= accept;
         s1_ed_q    <= ed;
      end
   end

   assign sum_ext = {1'b0, sum_q} + {{(SUM_W+1-P_W){1'b0}}, acc_ed};
   assign sum_d   = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
         err_q <= '0;
         sum_q <= '0;
         max_q <= '0;
      end else if (acc_vld) begin
         cnt_q <= cnt_q + CNT_W'(1);
         err_q <= err_q + CNT_W'(acc_ed != '0);
         sum_q <= sum_d;
         if (acc_ed > max_q) begin
            max_q <= acc_ed;
         end
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign sample_count_o = cnt_q;
   assign err_count_o    = err_q;
   assign sum_ed_o       = sum_q;
   assign max_ed_o       = max_q;
endmodule

// File: tb/tb_approx_err_accum.sv
// tb/tb_approx_err_accum.sv - self-checking bench for approx_err_accum (default and SUM_W=17 instances)
module tb_approx_err_accum;
   import approx_err_pkg::*;

`ifdef APPROX_ERR_SQ_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [15:0] n_samples = '0;
   logic        in_valid = 1'b0;
   logic [7:0]  a = '0, b = '0;
   logic [15:0] y = '0;

   logic        busy, done, busy17, done17;
   logic [15:0] cnt, err, cnt17, err17, max_ed, max17;
   logic [31:0] sum_ed;
   logic [16:0] sum17;
`ifdef APPROX_ERR_SQ_EN
   logic [63:0] sum_sq;
   logic [33:0] sum_sq17;
`endif

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   approx_err_accum_if #(.OP_W(8)) dif ();
   approx_err_accum_if #(.OP_W(8)) dif17 ();
   assign dif.in_valid   = in_valid;
   assign dif.in_a       = a;
   assign dif.in_b       = b;
   assign dif.in_y       = y;
   assign dif17.in_valid = in_valid;
   assign dif17.in_a     = a;
   assign dif17.in_b     = b;
   assign dif17.in_y     = y;

   approx_err_accum u_dut (
      .clk(clk), .rst(rst), .start_i(start), .n_samples_i(n_samples), .s_if(dif),
      .busy_o(busy), .done_o(done), .sample_count_o(cnt), .err_count_o(err),
      .sum_ed_o(sum_ed), .max_ed_o(max_ed)
`ifdef APPROX_ERR_SQ_EN
     ,.sum_sq_ed_o(sum_sq)
`endif
   );

   approx_err_accum #(.SUM_W(17)) u_dut17 (
      .clk(clk), .rst(rst), .start_i(start), .n_samples_i(n_samples), .s_if(dif17),
      .busy_o(busy17), .done_o(done17), .sample_count_o(cnt17), .err_count_o(err17),
      .sum_ed_o(sum17), .max_ed_o(max17)
`ifdef APPROX_ERR_SQ_EN
     ,.sum_sq_ed_o(sum_sq17)
`endif
   );

   typedef struct { longint ed; int land; } pend_t;
   pend_t  pq[$];
   int     cyc = 0;
   int     m_phase = 0;
   int     m_n = 0, m_acc = 0, m_drain = 0;
   bit     m_ready = 1'b0, m_acc_now;
   longint m_cnt = 0, m_err = 0, m_sum = 0, m_max = 0, m_sq = 0;
   pend_t  e;

   function automatic longint ed_of(input logic [7:0] fa, input logic [7:0] fb, input logic [15:0] fy);
      longint p;
      p = longint'(fa) * longint'(fb);
      return (p > longint'(fy)) ? p - longint'(fy) : longint'(fy) - p;
   endfunction

   function automatic longint sat(input longint v, input longint lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic clear_model();
      m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0; m_sq = 0;
   endtask

   // Spec-level model: accepted samples land LAT-1 edges after acceptance; DRAIN lasts LAT cycles.
   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         pq.delete();
         m_phase = 0; m_n = 0; m_acc = 0; m_ready = 1'b0;
         clear_model();
      end else begin
         while (pq.size() > 0 && pq[0].land <= cyc) begin
            e = pq.pop_front();
            m_cnt++;
            if (e.ed != 0) m_err++;
            m_sum += e.ed;
            m_sq  += e.ed * e.ed;
            if (e.ed > m_max) m_max = e.ed;
         end
         m_acc_now = in_valid && m_ready;
         if (m_acc_now) pq.push_back('{ed: ed_of(a, b, y), land: cyc + LAT - 1});
         case (m_phase)
            0, 3: if (start) begin
               clear_model();
               m_acc = 0;
               if (n_samples == 0) m_phase = 3;
               else begin m_phase = 1; m_n = int'(n_samples); end
            end
            1: if (m_acc_now) begin
               m_acc++;
               if (m_acc == m_n) begin m_phase = 2; m_drain = LAT; end
            end
            default: if (m_phase == 2) begin
               m_drain--;
               if (m_drain == 0) m_phase = 3;
            end
         endcase
         m_ready = (m_phase == 1) && (m_acc < m_n);
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", 64'(dif.in_ready), 64'(m_ready));
         chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
         chk("done", 64'(done), 64'(m_phase == 3));
         chk("sample_count", 64'(cnt), m_cnt);
         chk("err_count", 64'(err), m_err);
         chk("sum_ed", 64'(sum_ed), sat(m_sum, 64'hFFFF_FFFF));
         chk("max_ed", 64'(max_ed), m_max);
         chk("in_ready17", 64'(dif17.in_ready), 64'(m_ready));
         chk("sum_ed17", 64'(sum17), sat(m_sum, 131071));
         chk("err_count17", 64'(err17), m_err);
`ifdef APPROX_ERR_SQ_EN
         chk("sum_sq_ed", sum_sq, m_sq);
`endif
      end
   end

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic start_run(input int n);
      n_samples = 16'(n);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic send(input int sa, input int sb, input int sy);
      bit ok;
      a = 8'(sa); b = 8'(sb); y = 16'(sy);
      in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (dif.in_ready) begin
            @(posedge clk);
            ok = 1'b1;
         end
      end
      #1 in_valid = 1'b0;
      chk("send_timeout", 64'(ok), 64'd1);
   endtask

   task automatic wait_done();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (done) ok = 1'b1;
      end
      chk("done_timeout", 64'(ok), 64'd1);
   endtask

   initial begin
      do_reset();
      chk_en = 1'b1;
      @(negedge clk);
      chk("rst_ready", 64'(dif.in_ready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_count", 64'(cnt), 64'd0);

      start_run(4);
      send(3, 5, 15); send(255, 255, 65025); send(0, 7, 0); send(16, 16, 256);
      wait_done();
      chk("t1_count", 64'(cnt), 64'd4);
      chk("t1_err", 64'(err), 64'd0);
      chk("t1_sum", 64'(sum_ed), 64'd0);
      chk("t1_max", 64'(max_ed), 64'd0);

      start_run(3);
      send(10, 10, 103); send(12, 12, 140); send(255, 255, 0);
      wait_done();
      chk("t2_err", 64'(err), 64'd3);
      chk("t2_sum", 64'(sum_ed), 64'd65032);
      chk("t2_max", 64'(max_ed), 64'd65025);
`ifdef APPROX_ERR_SQ_EN
      chk("t2_sumsq", sum_sq, 64'd4228250650);
`endif

      start_run(0);
      @(negedge clk);
      chk("t3_done", 64'(done), 64'd1);
      chk("t3_count", 64'(cnt), 64'd0);
      chk("t3_ready", 64'(dif.in_ready), 64'd0);

      start_run(5);
      for (int i = 0; i < 14; i++) begin
         in_valid = (i % 2 == 0);
         a = 8'(i + 1); b = 8'(i + 3); y = 16'((i + 1) * (i + 3) + (i % 3));
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      wait_done();
      chk("t4_count", 64'(cnt), 64'd5);
      chk("t4_err", 64'(err), 64'd3);
      chk("t4_sum", 64'(sum_ed), 64'd5);
      chk("t4_max", 64'(max_ed), 64'd2);

      start_run(100);
      for (int i = 0; i < 40; i++) send(i, i, i * i + 1);
      do_reset();
      @(negedge clk);
      chk("t5_rst_count", 64'(cnt), 64'd0);
      chk("t5_rst_busy", 64'(busy), 64'd0);
      chk("t5_rst_sum", 64'(sum_ed), 64'd0);
      start_run(2);
      send(7, 9, 60); send(100, 100, 10010);
      wait_done();
      chk("t5_count", 64'(cnt), 64'd2);
      chk("t5_sum", 64'(sum_ed), 64'd13);
      chk("t5_max", 64'(max_ed), 64'd10);

      start_run(3);
      for (int i = 0; i < 3; i++) send(255, 255, 0);
      wait_done();
      chk("t6_sum17", 64'(sum17), 64'd131071);
      chk("t6_sum32", 64'(sum_ed), 64'd195075);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/approx_err_accum.md
Name: approx_err_accum

Overview:
- Downstream consumer of the 8x8 approximate recursive multiplier (M8_1-class output Y).
- Takes a stream of operand pairs and the approximate product, computes the exact product and the error distance ED = |a*b − Y|, and accumulates error metrics over a programmed sample count.
- Used in the characterisation bench and FPGA test harness to report error rate, total ED and maximum ED for each multiplier variant.

Parameters:
- OP_W, 8, operand width; the product width is 2*OP_W.
- CNT_W, 16, width of the sample counter and the n_samples input.
- SUM_W, 32, width of the ED sum accumulator.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a measurement run; sampled only in IDLE or DONE
- n_samples  in  CNT_W  number of samples to accept; latched on start
- in_valid  in  1  sample presented
- in_ready  out  1  block accepts a sample this cycle
- in_a  in  OP_W  operand a
- in_b  in  OP_W  operand b
- in_y  in  2*OP_W  approximate product for (in_a, in_b)
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE; results are stable
- sample_count  out  CNT_W  samples accumulated so far
- err_count  out  CNT_W  samples with ED != 0
- sum_ed  out  SUM_W  saturating sum of ED
- max_ed  out  2*OP_W  largest ED seen

Behaviour:
- Reset: state IDLE; in_ready=0, busy=0, done=0; all counters and accumulators are 0.
- State IDLE:
  - start=1 with n_samples>0: latch N, clear the accumulators, go to RUN.
  - start=1 with n_samples=0: go directly to DONE with all results 0.
- State RUN:
  - in_ready=1 while accepted<N. A sample is accepted when in_valid & in_ready.
  - Stage 1 registers ED. The exact product is OP_W×OP_W unsigned. ED = the absolute difference, 2*OP_W bits; it cannot overflow.
  - Stage 2 updates the accumulators on the cycle after acceptance. Latency from accept to sample_count increment is 2 cycles.
  - When the N-th sample is accepted, in_ready drops in the next cycle and the state goes to DRAIN.
- State DRAIN: wait until the stage-1 valid flag clears and the final update lands, then go to DONE. This takes at most 2 cycles.
- State DONE:
  - done=1; outputs hold.
  - start=1 clears the accumulators and re-enters RUN, or re-enters DONE if n_samples=0.
- start in RUN or DRAIN is ignored.
- in_valid while in_ready=0 is ignored; no sample is consumed.
- Accumulator rules:
  - sum_ed saturates at all-ones and never wraps.
  - err_count cannot exceed N, so no saturation is needed.
  - max_ed updates only when the new ED is strictly greater than the current value.
- rst mid-run: everything returns to reset values on the next edge. In-flight samples are discarded.
- Outputs in_ready, busy and done are registered, not combinational from inputs.

Optional Feature:
- Macro: APPROX_ERR_SQ_EN.
- When defined:
  - Add output sum_sq_ed (2*SUM_W bits), the saturating sum of ED², for MSE computation.
  - ED² is computed in a third pipeline stage, so accept-to-update latency becomes 3 cycles and DRAIN lasts up to 3 cycles.
- When undefined: the port is absent and latency is 2 cycles as above.

Decomposition:
- Shared package approx_err_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - default widths OP_W, CNT_W, SUM_W;
  - saturation helper constants (all-ones masks).
- One sub-module, approx_ed_unit: combinational exact product and absolute difference (a, b, y → ed). It is reused by other error-analysis blocks.

Test Plan:
- N=4, Y exact (e.g. 3*5=15, 255*255=65025, 0*7=0, 16*16=256) → done after the last update; err_count=0, sum_ed=0, max_ed=0, sample_count=4.
- N=3, samples (10,10,Y=103), (12,12,Y=140), (255,255,Y=0) → ED 3, 4, 65025; err_count=3, sum_ed=65032, max_ed=65025.
- n_samples=0 with start → done=1 on the next cycle, all results 0, in_ready never asserted.
- N=5 with in_valid toggling every other cycle, plus extra in_valid after the 5th → exactly 5 accepted; extra samples are ignored; in_ready=0 from the cycle after the 5th accept.
- Start a run of N=100, assert rst after 40 samples → all outputs 0, state IDLE; a new start with N=2 then gives correct results.
- Force sum_ed near saturation (SUM_W=17 build, repeated ED=65025) → sum_ed sticks at 131071 and does not wrap; with APPROX_ERR_SQ_EN, check sum_sq_ed = ΣED² for the N=3 case above.
